tx_cpl_to_buffer: RTL and testbench
===================================

# tx_cpl_to_buffer

- Receives PCIe completion-with-data TLPs on the TRN receive local-link and writes their payload into the local TX packet buffer, one QWord per cycle.
- Completions answer the 64-bit memory reads the TX engine issues against host huge pages. This block is the reading counterpart of the huge-page write path.
- Per-tag destination state is kept so that split completions land contiguously.
- Completions carrying an error status, and non-completion TLPs, are dropped.

## Interface
Parameters:
- `BF` (from includes.v): buffer address MSB; buffer address width is `BF`+1.

Ports:
- trn_clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trn_rd  in  64  RX data.
- trn_rrem_n  in  8  RX remainder; 0x00 means both DWs valid, 0x0F means only [63:32] valid.
- trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n  in  1 each  RX framing and valid.
- trn_rdst_rdy_n  out  1  RX ready, registered.
- cfg_completer_id  in  16  own requester ID.
- alloc_valid  in  1  one-cycle pulse registering a tag.
- alloc_tag  in  4  tag being registered.
- alloc_addr  in  `BF+1`  first buffer QW address for that tag.
- buf_full  in  1  buffer cannot accept writes.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  `BF+1`  buffer write address.
- wr_data  out  64  buffer write data.
- tag_done  out  1  one-cycle pulse: request fully completed.
- tag_done_tag  out  4  tag for tag_done.
- cpl_err  out  1  one-cycle pulse: completion with status ≠ 0.

## Operation
- **Tag table:** 16 entries of {next_addr}. On alloc_valid, next_addr[alloc_tag] <= alloc_addr.
  - Each written QW increments the entry; the increment wraps modulo 2^(`BF+1`).
  - If alloc_valid and a data write hit the same tag in the same cycle, the alloc wins.
- **Header, beat 0:**
  - DW0 = trn_rd[63:32]: fmt_type [62:56]; length [41:32], in DWs (0 means 1024).
  - DW1 = trn_rd[31:0]: status [15:13]; byte_count [11:0].
- **Header, beat 1:** DW2 = trn_rd[63:32]: requester ID [63:48]; tag [43:40]. trn_rd[31:0] is payload DW0.
- **Acceptance:** the TLP is accepted only if fmt_type == 7'b10_01010 (CplD), requester ID == cfg_completer_id, and status == 0.
  - Status ≠ 0 with a matching ID: pulse cpl_err and tag_done for that tag, then drain.
  - Anything else: drain silently.
- **QW assembly:**
  - Payload DW0 is held from beat 1.
  - Each later beat forms QW = {held DW, beat[63:32]}, then beat[31:0] becomes the new held DW.
  - wr_data is the byte-reverse of that QW: {Q[7:0], Q[15:8], …, Q[63:56]}.
  - If length is odd, the final QW is {held DW, 32'b0} with the same byte-reversal.
- **Final completion:** when byte_count == length×4 (or byte_count == 0 for length 1024), the TLP is the last one for its tag. tag_done pulses with tag_done_tag on the cycle of the last wr_en.
- **State machine:**
  - IDLE: on sof and valid, latch the header and go to HDR1.
  - HDR1: on valid, check acceptance and hold DW0; go to DATA, or to DRAIN if rejected.
  - DATA: write one QW per valid beat; at eof, flush per trn_rrem_n and length, then go to IDLE.
  - DRAIN: ignore beats until eof, then go to IDLE.
  - A sof seen outside IDLE is ignored.

## Timing
- **Reset values:** trn_rdst_rdy_n = 1, wr_en = 0, wr_addr = 0, wr_data = 0, tag_done = 0, tag_done_tag = 0, cpl_err = 0, state IDLE, tag table cleared.
- **Back-pressure:** trn_rdst_rdy_n <= buf_full, registered.
  - A beat is consumed only when trn_rsrc_rdy_n = 0 and trn_rdst_rdy_n = 0.
  - One beat may still arrive after buf_full rises; the buffer guarantees one slot of margin.
- **Write latency:** wr_en is registered and asserts on the cycle after the beat that completes a QW. wr_en is deasserted on every other cycle.
- **Throughput:** back-to-back TLPs are accepted with zero idle cycles. IDLE transitions on the same beat that carries sof.
- **Mid-TLP link-down:** reset aborts the TLP and clears all state; no tag_done is emitted.

## Structure
- The CplD fmt_type constant and the header field bit positions go in includes.v, shared with the TX read-request generator.
- The tag table (16×(`BF+1`) registers, one write port for alloc and one for increment, one async read port) is a natural sub-module: `cpl_tag_table`.

## Test plan
- **Single completion:** alloc tag 3 at 0x010; CplD with length = 8 DW, byte_count = 32, 4 data beats → 4 wr_en at addresses 0x010–0x013 with correctly byte-reversed data; tag_done with tag 3 on the 4th write.
- **Split completion:** tag 5 at 0x020; two CplDs of 16 DW each, byte_count 128 then 64 → 16 contiguous writes 0x020–0x02F; exactly one tag_done, after the 2nd TLP.
- **Odd length:** length = 3, byte_count = 12 → 2 writes, the second with the lower 32 bits zero before reversal.
- **Rejection:**
  - Wrong requester ID → no wr_en, no pulses.
  - Status = 3'b001 (UR) → cpl_err and tag_done with the tag, no wr_en.
  - MemWr TLP → drained, no outputs.
- **Back-pressure:** buf_full raised mid-TLP for 5 cycles → trn_rdst_rdy_n = 1 one cycle later; no data lost or duplicated; addresses stay contiguous.
- **Reset mid-TLP:** reset_n pulsed during DATA → all outputs return to reset values; the next completion is processed from IDLE correctly.

Source files
------------

// File: rtl/tx_cpl_to_buffer_pkg.sv
// ---------------------------------------------------------------------------
// tx_cpl_to_buffer_pkg
// Shared definitions for the completion-to-TX-buffer path: the CplD
// fmt_type constant, TLP header field bit positions (as seen on the 64-bit
// TRN receive bus), receive-remainder codes, the FSM state type and the
// QWord byte-reversal helper.
// ---------------------------------------------------------------------------
package tx_cpl_to_buffer_pkg;

  // Default buffer address MSB; the buffer address is BF+1 bits wide.
  localparam int BF_DEFAULT = 9;

  localparam int TAG_W     = 4;
  localparam int TAG_COUNT = 16;

  // Completion with data (3DW header, with payload).
  localparam logic [6:0] CPLD_FMT_TYPE = 7'b10_01010;
  // Type field shared by Cpl and CplD, regardless of format.
  localparam logic [4:0] CPL_TYPE      = 5'b01010;

  // Beat 0 fields (DW0 in [63:32], DW1 in [31:0]).
  localparam int FMT_HI    = 62;
  localparam int FMT_LO    = 56;
  localparam int LEN_HI    = 41;
  localparam int LEN_LO    = 32;
  localparam int STATUS_HI = 15;
  localparam int STATUS_LO = 13;
  localparam int BC_HI     = 11;
  localparam int BC_LO     = 0;

  // Beat 1 fields (DW2 in [63:32]).
  localparam int REQID_HI  = 63;
  localparam int REQID_LO  = 48;
  localparam int TAG_HI    = 43;
  localparam int TAG_LO    = 40;

  // trn_rrem_n code for a beat carrying both DWs.
  localparam logic [7:0] REM_BOTH = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR1,
    ST_DATA,
    ST_DRAIN
  } cpl_state_t;

  // Host data arrives big-endian per DW pair; the buffer wants the
  // QWord with its eight bytes in reverse order.
  function automatic logic [63:0] byte_reverse(input logic [63:0] q);
    return {q[7:0],   q[15:8],  q[23:16], q[31:24],
            q[39:32], q[47:40], q[55:48], q[63:56]};
  endfunction

endpackage

// File: rtl/tx_cpl_to_buffer_tag_table.sv
// ---------------------------------------------------------------------------
// cpl_tag_table
// Per-tag destination pointer table: 16 entries holding the next buffer
// QWord address for each outstanding read tag.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (clears table)
//   alloc_valid/tag/addr  load an entry with a fresh start address
//   inc_valid/tag         advance an entry by one QWord (wraps at 2^AW)
//   rd_tag / rd_addr      asynchronous read port
// ---------------------------------------------------------------------------
module cpl_tag_table
  import tx_cpl_to_buffer_pkg::*;
#(
  parameter int AW = BF_DEFAULT + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [AW-1:0]    alloc_addr,
  input  logic             inc_valid,
  input  logic [TAG_W-1:0] inc_tag,
  input  logic [TAG_W-1:0] rd_tag,
  output logic [AW-1:0]    rd_addr
);

  logic [AW-1:0] next_addr [TAG_COUNT];

  // A new allocation overrides a same-cycle increment of the same tag,
  // so a re-used tag always starts at its freshly assigned address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_COUNT; i++) begin
        next_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAG_COUNT; i++) begin
        if (alloc_valid && (alloc_tag == TAG_W'(i))) begin
          next_addr[i] <= alloc_addr;
        end else if (inc_valid && (inc_tag == TAG_W'(i))) begin
          next_addr[i] <= next_addr[i] + AW'(1);
        end
      end
    end
  end

  assign rd_addr = next_addr[rd_tag];

endmodule

// File: rtl/tx_cpl_to_buffer.sv
// ---------------------------------------------------------------------------
// tx_cpl_to_buffer
// Takes PCIe completion-with-data TLPs from the TRN receive local-link and
// writes their payload, one byte-reversed QWord per cycle, into the local
// TX packet buffer at the address tracked for the completion's tag.
// Error-status completions pulse cpl_err/tag_done; everything else that is
// not ours is drained.
//
// Ports:
//   trn_clk, reset_n         clock, asynchronous active-low reset
//   trn_rd/rrem_n/rsof_n/
//   reof_n/rsrc_rdy_n        receive local-link (data, remainder, framing)
//   trn_rdst_rdy_n           registered receive ready (follows buf_full)
//   cfg_completer_id         our own requester ID
//   alloc_valid/tag/addr     register a tag's starting buffer address
//   buf_full                 buffer back-pressure
//   wr_en/wr_addr/wr_data    buffer write port
//   tag_done/tag_done_tag    request for that tag is finished
//   cpl_err                  completion returned with non-zero status
// ---------------------------------------------------------------------------
module tx_cpl_to_buffer
  import tx_cpl_to_buffer_pkg::*;
#(
  parameter int BF = BF_DEFAULT
) (
  input  logic             trn_clk,
  input  logic             reset_n,
  input  logic [63:0]      trn_rd,
  input  logic [7:0]       trn_rrem_n,
  input  logic             trn_rsof_n,
  input  logic             trn_reof_n,
  input  logic             trn_rsrc_rdy_n,
  output logic             trn_rdst_rdy_n,
  input  logic [15:0]      cfg_completer_id,
  input  logic             alloc_valid,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [BF:0]      alloc_addr,
  input  logic             buf_full,
  output logic             wr_en,
  output logic [BF:0]      wr_addr,
  output logic [63:0]      wr_data,
  output logic             tag_done,
  output logic [TAG_W-1:0] tag_done_tag,
  output logic             cpl_err
);

  cpl_state_t state, next_state;

  logic             beat;
  logic             sof;
  logic             eof;

  logic [6:0]       hdr_fmt_type;
  logic [9:0]       hdr_length;
  logic [2:0]       hdr_status;
  logic [11:0]      hdr_byte_count;
  logic [TAG_W-1:0] cur_tag;
  logic [31:0]      held_dw;
  logic             flush_pending;
  logic             flush_last;

  logic [15:0]      rx_req_id;
  logic [TAG_W-1:0] rx_tag;
  logic             id_match;
  logic             accept;
  logic             err_hit;
  logic             is_last;
  logic             odd_tail;

  logic             do_write;
  logic             write_last;
  logic             err_pulse;
  logic             set_flush;
  logic [63:0]      write_qw;
  logic [BF:0]      tbl_addr;

  assign beat = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign sof  = !trn_rsof_n;
  assign eof  = !trn_reof_n;

  assign rx_req_id = trn_rd[REQID_HI:REQID_LO];
  assign rx_tag    = trn_rd[TAG_HI:TAG_LO];
  assign id_match  = (rx_req_id == cfg_completer_id);

  assign accept  = (hdr_fmt_type == CPLD_FMT_TYPE) && id_match && (hdr_status == 3'b000);
  // Error reporting applies to any completion (Cpl or CplD) for our ID.
  assign err_hit = (hdr_fmt_type[4:0] == CPL_TYPE) && id_match && (hdr_status != 3'b000);

  // 12-bit compare: a length of 0 (1024 DWs) times four wraps to 0, which
  // is exactly the byte_count a final 4 KB completion carries.
  assign is_last = (hdr_byte_count == {hdr_length, 2'b00});

  // A full last beat of an odd-length payload leaves one DW held back that
  // still needs its own (zero-padded) write on the following cycle.
  assign odd_tail = (trn_rrem_n == REM_BOTH) && hdr_length[0];

  cpl_tag_table #(
    .AW          (BF + 1)
  ) u_tag_table (
    .clk         (trn_clk),
    .rst_n       (reset_n),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .alloc_addr  (alloc_addr),
    .inc_valid   (do_write),
    .inc_tag     (cur_tag),
    .rd_tag      (cur_tag),
    .rd_addr     (tbl_addr)
  );

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (beat && sof) next_state = ST_HDR1;
      end
      ST_HDR1: begin
        if (beat) begin
          if (eof)         next_state = ST_IDLE;
          else if (accept) next_state = ST_DATA;
          else             next_state = ST_DRAIN;
        end
      end
      ST_DATA: begin
        if (beat && eof) next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        if (beat && eof) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The odd-tail flush always lands in IDLE (the cycle after DATA's eof),
  // which never produces a write of its own, so the two cannot collide.
  always_comb begin
    do_write   = 1'b0;
    write_last = 1'b0;
    err_pulse  = 1'b0;
    set_flush  = 1'b0;
    write_qw   = '0;
    case (state)
      ST_HDR1: begin
        if (beat) begin
          if (accept && eof && hdr_length[0]) set_flush = 1'b1;
          if (err_hit)                        err_pulse = 1'b1;
        end
      end
      ST_DATA: begin
        if (beat) begin
          do_write = 1'b1;
          write_qw = {held_dw, trn_rd[63:32]};
          if (eof) begin
            if (odd_tail) set_flush  = 1'b1;
            else          write_last = is_last;
          end
        end
      end
      default: ;
    endcase
    if (flush_pending) begin
      do_write   = 1'b1;
      write_qw   = {held_dw, 32'h0000_0000};
      write_last = flush_last;
    end
  end

  // Header capture and the payload DW carried between beats.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_fmt_type   <= '0;
      hdr_length     <= '0;
      hdr_status     <= '0;
      hdr_byte_count <= '0;
      cur_tag        <= '0;
      held_dw        <= '0;
      flush_pending  <= 1'b0;
      flush_last     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && beat && sof) begin
        hdr_fmt_type   <= trn_rd[FMT_HI:FMT_LO];
        hdr_length     <= trn_rd[LEN_HI:LEN_LO];
        hdr_status     <= trn_rd[STATUS_HI:STATUS_LO];
        hdr_byte_count <= trn_rd[BC_HI:BC_LO];
      end
      if ((state == ST_HDR1) && beat) begin
        cur_tag <= rx_tag;
        held_dw <= trn_rd[31:0];
      end
      if ((state == ST_DATA) && beat) begin
        held_dw <= trn_rd[31:0];
      end
      flush_pending <= set_flush;
      if (set_flush) flush_last <= is_last;
    end
  end

  // Registered outputs; address and data hold between writes.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      trn_rdst_rdy_n <= 1'b1;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      tag_done       <= 1'b0;
      tag_done_tag   <= '0;
      cpl_err        <= 1'b0;
    end else begin
      trn_rdst_rdy_n <= buf_full;
      wr_en          <= do_write;
      if (do_write) begin
        wr_addr <= tbl_addr;
        wr_data <= byte_reverse(write_qw);
      end
      tag_done <= (do_write && write_last) || err_pulse;
      if (do_write && write_last) begin
        tag_done_tag <= cur_tag;
      end else if (err_pulse) begin
        tag_done_tag <= rx_tag;
      end
      cpl_err <= err_pulse;
    end
  end

endmodule

// File: tb/tb_tx_cpl_to_buffer.sv
// ---------------------------------------------------------------------------
// tb_tx_cpl_to_buffer
// Scoreboard bench for tx_cpl_to_buffer: every TLP driven pushes the writes
// (or error pulse) it should cause; a monitor pops and compares them as the
// DUT produces buffer writes and pulses.
// ---------------------------------------------------------------------------
module tb_tx_cpl_to_buffer;

  localparam int          AW     = 10;
  localparam logic [15:0] CFG_ID = 16'h0A00;
  localparam logic [6:0]  FT_CPLD  = 7'b10_01010;
  localparam logic [6:0]  FT_MEMWR = 7'b10_00000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    bit            last;
    logic [3:0]    tag;
  } exp_wr_t;

  logic          trn_clk;
  logic          reset_n;
  logic [63:0]   trn_rd;
  logic [7:0]    trn_rrem_n;
  logic          trn_rsof_n;
  logic          trn_reof_n;
  logic          trn_rsrc_rdy_n;
  logic          trn_rdst_rdy_n;
  logic          alloc_valid;
  logic [3:0]    alloc_tag;
  logic [AW-1:0] alloc_addr;
  logic          buf_full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          tag_done;
  logic [3:0]    tag_done_tag;
  logic          cpl_err;

  int            compareCount = 0;
  int            mismatchCount = 0;
  exp_wr_t       expWr[$];
  logic [3:0]    expErr[$];
  logic [AW-1:0] modelAddr [16];

  tx_cpl_to_buffer #(
    .BF               (AW - 1)
  ) dut (
    .trn_clk          (trn_clk),
    .reset_n          (reset_n),
    .trn_rd           (trn_rd),
    .trn_rrem_n       (trn_rrem_n),
    .trn_rsof_n       (trn_rsof_n),
    .trn_reof_n       (trn_reof_n),
    .trn_rsrc_rdy_n   (trn_rsrc_rdy_n),
    .trn_rdst_rdy_n   (trn_rdst_rdy_n),
    .cfg_completer_id (CFG_ID),
    .alloc_valid      (alloc_valid),
    .alloc_tag        (alloc_tag),
    .alloc_addr       (alloc_addr),
    .buf_full         (buf_full),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .tag_done         (tag_done),
    .tag_done_tag     (tag_done_tag),
    .cpl_err          (cpl_err)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] byteReverse(input logic [63:0] q);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = q[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mkDw0(input logic [6:0] fmt, input logic [9:0] len);
    return {1'b0, fmt, 14'h0, len};
  endfunction

  function automatic logic [31:0] mkDw1(input logic [2:0] status, input logic [11:0] bc);
    return {16'h0100, status, 1'b0, bc};
  endfunction

  function automatic logic [31:0] mkDw2(input logic [15:0] reqId, input logic [3:0] tag);
    return {reqId, 4'h0, tag, 8'h00};
  endfunction

  // Drives one beat (called at a falling edge) and holds it until taken.
  task automatic sendBeat(input logic [63:0] d, input logic [7:0] rem, input bit sof, input bit eof);
    bit took = 0;
    int waited = 0;
    trn_rd         = d;
    trn_rrem_n     = rem;
    trn_rsof_n     = !sof;
    trn_reof_n     = !eof;
    trn_rsrc_rdy_n = 1'b0;
    while (!took && waited < 200) begin
      took = !trn_rdst_rdy_n;
      @(negedge trn_clk);
      waited++;
    end
    if (!took) checkOutput("beat_accept_timeout", 64'(took), 64'd1);
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
  endtask

  task automatic allocTag(input logic [3:0] tag, input logic [AW-1:0] addr);
    alloc_valid = 1'b1;
    alloc_tag   = tag;
    alloc_addr  = addr;
    @(negedge trn_clk);
    alloc_valid = 1'b0;
    modelAddr[tag] = addr;
  endtask

  // Builds a TLP, predicts its effect on the scoreboard, then drives it.
  task automatic applyStimulus(input logic [6:0] fmt, input logic [9:0] len, input logic [2:0] status,
                               input logic [11:0] bc, input logic [15:0] reqId, input logic [3:0] tag,
                               input int npay);
    logic [31:0] dws[$];
    logic [31:0] pay[$];
    exp_wr_t     e;
    bit          isFinal;
    int          nq;
    int          n;
    int          nb;
    for (int i = 0; i < npay; i++) pay.push_back($urandom);
    dws.push_back(mkDw0(fmt, len));
    dws.push_back(mkDw1(status, bc));
    dws.push_back(mkDw2(reqId, tag));
    foreach (pay[i]) dws.push_back(pay[i]);
    isFinal = (len == 10'd0) ? (bc == 12'd0) : (int'(bc) == int'(len) * 4);
    if (fmt == FT_CPLD && reqId == CFG_ID && status == 3'd0) begin
      nq = (npay + 1) / 2;
      for (int k = 0; k < nq; k++) begin
        e.addr = modelAddr[tag];
        e.data = byteReverse({pay[2*k], (2*k+1 < npay) ? pay[2*k+1] : 32'h0});
        e.last = (k == nq - 1) && isFinal;
        e.tag  = tag;
        expWr.push_back(e);
        modelAddr[tag] = modelAddr[tag] + 1'b1;
      end
    end else if (fmt[4:0] == 5'b01010 && reqId == CFG_ID && status != 3'd0) begin
      expErr.push_back(tag);
    end
    n  = dws.size();
    nb = (n + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      sendBeat({dws[2*b], (2*b+1 < n) ? dws[2*b+1] : 32'hDEAD_BEEF},
               (2*b+1 < n) ? 8'h00 : 8'h0F, b == 0, b == nb - 1);
    end
  endtask

  task automatic waitDrained(input string name);
    int waited = 0;
    repeat (4) @(negedge trn_clk);
    while ((expWr.size() != 0 || expErr.size() != 0) && waited < 2000) begin
      @(negedge trn_clk);
      waited++;
    end
    repeat (3) @(negedge trn_clk);
    checkOutput({name, "_writes_left"}, 64'(expWr.size()), 64'd0);
    checkOutput({name, "_errs_left"}, 64'(expErr.size()), 64'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_rdst_rdy_n"}, 64'(trn_rdst_rdy_n), 64'd1);
    checkOutput({name, "_wr_en"}, 64'(wr_en), 64'd0);
    checkOutput({name, "_wr_addr"}, 64'(wr_addr), 64'd0);
    checkOutput({name, "_wr_data"}, wr_data, 64'd0);
    checkOutput({name, "_tag_done"}, 64'(tag_done), 64'd0);
    checkOutput({name, "_tag_done_tag"}, 64'(tag_done_tag), 64'd0);
    checkOutput({name, "_cpl_err"}, 64'(cpl_err), 64'd0);
  endtask

  // Scoreboard consumer: outputs are registered, so the falling edge sees
  // them stable.
  always @(negedge trn_clk) begin : monitor
    exp_wr_t    e;
    logic [3:0] et;
    if (reset_n) begin
      if (wr_en) begin
        if (expWr.size() == 0) begin
          checkOutput("spurious_wr_en", 64'(wr_en), 64'd0);
        end else begin
          e = expWr.pop_front();
          checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
          checkOutput("wr_data", wr_data, e.data);
          checkOutput("tag_done_on_wr", 64'(tag_done), 64'(e.last));
          if (e.last) checkOutput("tag_done_tag", 64'(tag_done_tag), 64'(e.tag));
          checkOutput("cpl_err_on_wr", 64'(cpl_err), 64'd0);
        end
      end else if (tag_done || cpl_err) begin
        if (expErr.size() == 0) begin
          checkOutput("spurious_tag_done", 64'(tag_done), 64'd0);
          checkOutput("spurious_cpl_err", 64'(cpl_err), 64'd0);
        end else begin
          et = expErr.pop_front();
          checkOutput("err_cpl_err", 64'(cpl_err), 64'd1);
          checkOutput("err_tag_done", 64'(tag_done), 64'd1);
          checkOutput("err_tag", 64'(tag_done_tag), 64'(et));
        end
      end
    end
  end

  initial begin
    logic [31:0] p0, p1, p2;
    exp_wr_t     e;
    reset_n        = 1'b0;
    trn_rd         = '0;
    trn_rrem_n     = 8'h00;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    alloc_valid    = 1'b0;
    alloc_tag      = '0;
    alloc_addr     = '0;
    buf_full       = 1'b0;
    for (int i = 0; i < 16; i++) modelAddr[i] = '0;
    repeat (3) @(negedge trn_clk);
    checkResetValues("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge trn_clk);

    $display("[TB] single completion");
    allocTag(4'd3, 10'h010);
    applyStimulus(FT_CPLD, 10'd8, 3'd0, 12'd32, CFG_ID, 4'd3, 8);
    waitDrained("single");

    $display("[TB] split completion, back to back");
    allocTag(4'd5, 10'h020);
    applyStimulus(FT_CPLD, 10'd16, 3'd0, 12'd128, CFG_ID, 4'd5, 16);
    applyStimulus(FT_CPLD, 10'd16, 3'd0, 12'd64, CFG_ID, 4'd5, 16);
    waitDrained("split");

    $display("[TB] odd length");
    allocTag(4'd6, 10'h030);
    applyStimulus(FT_CPLD, 10'd3, 3'd0, 12'd12, CFG_ID, 4'd6, 3);
    waitDrained("odd");

    $display("[TB] wrong requester id, then a good one for the same tag");
    allocTag(4'd8, 10'h040);
    applyStimulus(FT_CPLD, 10'd4, 3'd0, 12'd16, 16'h0B00, 4'd8, 4);
    applyStimulus(FT_CPLD, 10'd2, 3'd0, 12'd8, CFG_ID, 4'd8, 2);
    waitDrained("wrong_id");

    $display("[TB] unsupported-request status");
    applyStimulus(FT_CPLD, 10'd0, 3'b001, 12'd0, CFG_ID, 4'd9, 0);
    waitDrained("ur");

    $display("[TB] memory write drained");
    applyStimulus(FT_MEMWR, 10'd4, 3'd0, 12'd16, CFG_ID, 4'd3, 4);
    waitDrained("memwr");

    $display("[TB] back-pressure with address wrap");
    allocTag(4'd10, 10'h3FE);
    fork
      applyStimulus(FT_CPLD, 10'd16, 3'd0, 12'd64, CFG_ID, 4'd10, 16);
      begin
        repeat (4) @(negedge trn_clk);
        checkOutput("bp_rdy_before", 64'(trn_rdst_rdy_n), 64'd0);
        buf_full = 1'b1;
        @(negedge trn_clk);
        checkOutput("bp_rdy_asserted", 64'(trn_rdst_rdy_n), 64'd1);
        repeat (4) @(negedge trn_clk);
        buf_full = 1'b0;
        @(negedge trn_clk);
        checkOutput("bp_rdy_released", 64'(trn_rdst_rdy_n), 64'd0);
      end
    join
    waitDrained("backpressure");

    $display("[TB] 1024-DW completion");
    allocTag(4'd11, 10'h100);
    applyStimulus(FT_CPLD, 10'd0, 3'd0, 12'd0, CFG_ID, 4'd11, 1024);
    waitDrained("len1024");

    $display("[TB] reset in the middle of a TLP");
    allocTag(4'd7, 10'h100);
    p0 = $urandom;
    p1 = $urandom;
    p2 = $urandom;
    e.addr = 10'h100;
    e.data = byteReverse({p0, p1});
    e.last = 1'b0;
    e.tag  = 4'd7;
    expWr.push_back(e);
    sendBeat({mkDw0(FT_CPLD, 10'd4), mkDw1(3'd0, 12'd16)}, 8'h00, 1'b1, 1'b0);
    sendBeat({mkDw2(CFG_ID, 4'd7), p0}, 8'h00, 1'b0, 1'b0);
    sendBeat({p1, p2}, 8'h00, 1'b0, 1'b0);
    @(negedge trn_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge trn_clk);
    checkResetValues("midreset");
    checkOutput("midreset_writes_left", 64'(expWr.size()), 64'd0);
    for (int i = 0; i < 16; i++) modelAddr[i] = '0;
    reset_n = 1'b1;
    @(negedge trn_clk);
    applyStimulus(FT_CPLD, 10'd2, 3'd0, 12'd8, CFG_ID, 4'd3, 2);
    waitDrained("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
